// File: rtl/ahb_imem_arbiter.sv
// Two-master AHB-Lite arbiter in front of the single-port instruction RAM.
// A losing address phase is buffered and replayed; the slave data phase is routed to its owner.
module ahb_imem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,

    input  logic              m0_hsel,
    input  logic [ADDR_W-1:0] m0_haddr,
    input  logic [1:0]        m0_htrans,
    input  logic              m0_hwrite,
    input  logic [2:0]        m0_hsize,
    input  logic [2:0]        m0_hburst,
    input  logic [3:0]        m0_hprot,
    input  logic [DATA_W-1:0] m0_hwdata,
    output logic [DATA_W-1:0] m0_hrdata,
    output logic              m0_hready,
    output logic              m0_hresp,

    input  logic              m1_hsel,
    input  logic [ADDR_W-1:0] m1_haddr,
    input  logic [1:0]        m1_htrans,
    input  logic              m1_hwrite,
    input  logic [2:0]        m1_hsize,
    input  logic [2:0]        m1_hburst,
    input  logic [3:0]        m1_hprot,
    input  logic [DATA_W-1:0] m1_hwdata,
    output logic [DATA_W-1:0] m1_hrdata,
    output logic              m1_hready,
    output logic              m1_hresp,

    output logic [ADDR_W-1:0] s_haddr,
    output logic [1:0]        s_htrans,
    output logic              s_hwrite,
    output logic [2:0]        s_hsize,
    output logic [2:0]        s_hburst,
    output logic [3:0]        s_hprot,
    output logic [DATA_W-1:0] s_hwdata,
    input  logic [DATA_W-1:0] s_hrdata,
    input  logic              s_hready,
    input  logic              s_hresp,

    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StPend,
        StData
    } mst_st_e;

    typedef struct packed {
        logic [ADDR_W-1:0] haddr;
        logic [1:0]        htrans;
        logic              hwrite;
        logic [2:0]        hsize;
        logic [2:0]        hburst;
        logic [3:0]        hprot;
    } addr_ph_t;

    mst_st_e     st_q    [2];
    addr_ph_t    buf_q   [2];
    addr_ph_t    live_ph [2];
    addr_ph_t    sel_ph;
    logic        last_grant_q;
    logic [15:0] stall_cnt_q;

    logic [1:0]  pend;
    logic [1:0]  owner;
    logic [1:0]  hready_m;
    logic [1:0]  live_req;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        tie_to_m0;

    always_comb begin
        live_ph[0] = {m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hprot};
        live_ph[1] = {m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hprot};
    end

    // A stalled owner sees hready=0, so it can never present a new request mid data phase.
    always_comb begin
        pend     = '0;
        owner    = '0;
        hready_m = '1;
        for (int n = 0; n < 2; n++) begin
            pend[n]     = (st_q[n] == StPend);
            owner[n]    = (st_q[n] == StData);
            hready_m[n] = owner[n] ? s_hready : ~pend[n];
        end
    end

    always_comb begin
        live_req[0] = m0_hsel & m0_htrans[1] & hready_m[0];
        live_req[1] = m1_hsel & m1_htrans[1] & hready_m[1];
        req         = live_req | pend;
    end

    // last_grant resets to master 1 so master 0 wins the first tie.
    always_comb begin
        tie_to_m0 = (FIXED_PRIO != 0) || last_grant_q;
        gnt       = 2'b00;
        if (s_hready) begin
            if (req[0] && (!req[1] || tie_to_m0)) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end
    end

    always_comb begin
        sel_ph = '0;
        unique case (gnt)
            2'b01:   sel_ph = pend[0] ? buf_q[0] : live_ph[0];
            2'b10:   sel_ph = pend[1] ? buf_q[1] : live_ph[1];
            default: sel_ph = '0;
        endcase
    end

    assign s_haddr  = sel_ph.haddr;
    assign s_htrans = sel_ph.htrans;
    assign s_hwrite = sel_ph.hwrite;
    assign s_hsize  = sel_ph.hsize;
    assign s_hburst = sel_ph.hburst;
    assign s_hprot  = sel_ph.hprot;

    always_comb begin
        s_hwdata = '0;
        unique case (owner)
            2'b01:   s_hwdata = m0_hwdata;
            2'b10:   s_hwdata = m1_hwdata;
            default: s_hwdata = '0;
        endcase
    end

    assign m0_hready = hready_m[0];
    assign m1_hready = hready_m[1];
    assign m0_hresp  = owner[0] & s_hresp;
    assign m1_hresp  = owner[1] & s_hresp;
    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign stall_cnt = stall_cnt_q;

    // Per-master IDLE/PEND/DATA tracking; DATA doubles as data-phase ownership.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int n = 0; n < 2; n++) begin
                st_q[n]  <= StIdle;
                buf_q[n] <= '0;
            end
            last_grant_q <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                unique case (st_q[n])
                    StIdle: begin
                        if (gnt[n]) begin
                            st_q[n] <= StData;
                        end else if (live_req[n]) begin
                            st_q[n]  <= StPend;
                            buf_q[n] <= live_ph[n];
                        end
                    end
                    StPend: begin
                        if (gnt[n]) begin
                            st_q[n] <= StData;
                        end
                    end
                    StData: begin
                        if (s_hready) begin
                            if (gnt[n]) begin
                                st_q[n] <= StData;
                            end else if (live_req[n]) begin
                                st_q[n]  <= StPend;
                                buf_q[n] <= live_ph[n];
                            end else begin
                                st_q[n] <= StIdle;
                            end
                        end
                    end
                    default: st_q[n] <= StIdle;
                endcase
            end
            if (|gnt) begin
                last_grant_q <= gnt[1];
            end
            if ((|pend) && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: doc/ahb_imem_arbiter.md
# ahb_imem_arbiter

Two-master AHB-Lite arbiter in front of the single-port instruction RAM (`cpu_mem`). It lets the CPU instruction bus (master 0) and a system-bus window into instruction space (master 1) share the RAM. Master 1 is used for program loading, debug patching and data reads from code space. The block buffers a losing master's address phase, stalls that master through its own hready, and routes the slave data phase back to whichever master owns it. Uncontended transfers see zero added latency.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `FIXED_PRIO`, 0, 0 = round-robin between masters; 1 = master 0 always wins
- `sys_clk  in  1  system clock; all state on rising edge`
- `sys_rst  in  1  reset, synchronous, active-high`
- `mN_hsel  in  1  (N=0,1) slave select for this port`
- `mN_haddr  in  ADDR_W  address`
- `mN_htrans  in  2  transfer type`
- `mN_hwrite  in  1  write enable`
- `mN_hsize  in  3  size`
- `mN_hburst  in  3  burst, passed through`
- `mN_hprot  in  4  protection, passed through`
- `mN_hwdata  in  DATA_W  write data (data phase)`
- `mN_hrdata  out  DATA_W  read data`
- `mN_hready  out  1  ready to master`
- `mN_hresp  out  1  0 OKAY, 1 ERROR`
- `s_haddr / s_htrans / s_hwrite / s_hsize / s_hburst / s_hprot / s_hwdata  out  as above  to RAM`
- `s_hrdata  in  DATA_W; s_hready  in  1; s_hresp  in  1  from RAM`
- `stall_cnt  out  16  saturating count of cycles any master is held in PEND`

## Operation
- Request: `reqN = mN_hsel & mN_htrans[1] & mN_hready` (new address phase), or `pendN` (buffered).
- Per-master state:
  - IDLE → DATA when granted.
  - IDLE → PEND when requesting but not granted; capture haddr/htrans/hwrite/hsize/hburst/hprot into buffer N.
  - PEND → DATA when granted.
  - DATA → IDLE when s_hready=1 and no new grant to that master.
  - DATA → DATA when s_hready=1 and granted again (pipelined).
  - DATA → PEND when s_hready=1, a new request arrives and it is not granted.
- Grant is issued only in cycles with s_hready=1, at most one master per cycle:
  - Only one requester: it wins.
  - Both requesting, FIXED_PRIO=1: master 0 wins.
  - Both requesting, FIXED_PRIO=0: the master not equal to `last_grant` wins; `last_grant` updates on every grant.
- Address mux: granted master's buffer if pend, else its live signals. With no grant, s_htrans=IDLE (2'b00), s_haddr=0, and other controls are 0.
- `dp_owner` (NONE/0/1) is registered from the grant when s_hready=1. It selects s_hwdata and which master receives s_hready/s_hresp.
- mN_hready:
  - owner: s_hready
  - PEND: 0
  - otherwise: 1
- mN_hresp: s_hresp if owner, else 0. A two-cycle ERROR (hresp=1 with hready=0, then hresp=1 with hready=1) is forwarded unaltered.
- s_hrdata is broadcast to both mN_hrdata.
- IDLE/BUSY htrans, or hsel=0, is never a request and is never buffered.
- stall_cnt increments in each cycle where pend0|pend1 is set and saturates at 0xFFFF.

## Timing
- Reset (sys_rst=1 at a clock edge) gives:
  - all masters IDLE, pend=0, dp_owner=NONE, last_grant=1 (master 0 wins first tie), stall_cnt=0
  - mN_hready=1, mN_hresp=0, s_htrans=IDLE
- Reset mid-transfer: the slave data phase in flight is abandoned and no response is forwarded.
- Uncontended: the address reaches s_* in the same cycle (combinational). Data phase latency equals RAM latency.
- Contended: the loser is issued from its buffer at the next s_hready=1 cycle. Minimum penalty is 1 cycle, seen as mN_hready=0.
- While s_hready=0 no new grant is made. New requests are still captured into PEND.
- Simultaneous release of owner and new request from the same master: the data phase completes and the new grant happens in the same cycle.
- Arbitration is fair under round-robin: with both masters streaming, grants alternate every accepted address.

## Test plan
- Reset: sys_rst=1 for 2 cycles → m0/m1_hready=1, hresp=0, s_htrans=00, stall_cnt=0.
- Single master: m0 NONSEQ read at 0x100 → s_haddr=0x100 in the same cycle, m0_hrdata=RAM word next cycle, m1_hready stays 1.
- Collision after reset: m0 read 0x10 and m1 write 0x20/0xDEADBEEF in the same cycle → m0 granted first. m1_hready=0 for 1 cycle, then the write is issued from the buffer with hwdata=0xDEADBEEF. stall_cnt=1.
- Round-robin streaming: both masters issue 8 back-to-back NONSEQ each → grants alternate 0,1,0,1…. FIXED_PRIO=1 run → all 8 m0 transfers first.
- RAM wait states: s_hready held low 3 cycles during m1's data phase while m0 requests → m0 stays PEND, its buffered address is issued once s_hready=1, and stall_cnt=3+1.
- Error: RAM returns two-cycle ERROR to m0's access → m0_hresp=1 both cycles, m0_hready 0 then 1, m1_hresp=0 throughout. Reset asserted mid data phase → all outputs return to reset values the next cycle.
